// File: rtl/relay_alu_pkg.sv
// Purpose: shared types and constants for the relay ALU issue sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: alu_fn_e (fff codes), ALU_CLASS_OP (upper nibble of ALU-class bytes),
//           seq_state_e (sequencer states), flags_t (Z/S/C), fn_sets_carry helper.
package relay_alu_pkg;

   typedef enum logic [2:0] {
      FN_ADD = 3'b000,
      FN_INC = 3'b001,
      FN_AND = 3'b010,
      FN_OR  = 3'b011,
      FN_XOR = 3'b100,
      FN_NOT = 3'b101,
      FN_SHL = 3'b110,
      FN_CLR = 3'b111
   } alu_fn_e;

   localparam logic [3:0] ALU_CLASS_OP = 4'b1000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SETTLE = 2'd2,
      WRITE  = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic z;
      logic s;
      logic c;
   } flags_t;

   // Only the adder functions produce a meaningful carry; every other
   // function clears the carry flag.
   function automatic logic fn_sets_carry(alu_fn_e fn);
      return (fn == FN_ADD) || (fn == FN_INC);
   endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Purpose: bundles the instruction handshake, operand/ALU bus and writeback/flag signals.
// Latency: n/a (wiring only).
// Backpressure: instr_valid/instr_ready handshake; the offer is held by the source until ready.
// Modports: slave = the sequencer (consumes instructions, drives the ALU and writeback);
//           master = instruction source, register file and ALU datapath side.
interface alu_instr_sequencer_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr;
   logic [7:0] reg_b;
   logic [7:0] reg_c;
   logic [7:0] alu_b;
   logic [7:0] alu_c;
   logic [2:0] alu_fn;
   logic       alu_en;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       dest_we;
   logic       dest_sel;
   logic [7:0] dest_data;
   logic       flag_z;
   logic       flag_s;
   logic       flag_c;
   logic       done;
   logic       illegal;

   modport slave (
      input  instr_valid, instr, reg_b, reg_c, alu_result, alu_carry,
      output instr_ready, alu_b, alu_c, alu_fn, alu_en,
             dest_we, dest_sel, dest_data, flag_z, flag_s, flag_c, done, illegal
   );

   modport master (
      output instr_valid, instr, reg_b, reg_c, alu_result, alu_carry,
      input  instr_ready, alu_b, alu_c, alu_fn, alu_en,
             dest_we, dest_sel, dest_data, flag_z, flag_s, flag_c, done, illegal
   );
endinterface

// File: rtl/alu_settle_timer.sv
// Purpose: 4-bit load/decrement counter timing the relay settle window.
// Latency: tc asserts load_val cycles after the load edge (same cycle when load_val=0).
// Backpressure: none; the counter holds at 0 rather than wrapping.
// Ports: clk, rst_n (async active-low), load/load_val (preset), dec (count down), tc (count == 0).
module alu_settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       tc
);
   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == 4'd0);
endmodule

// File: rtl/alu_instr_sequencer.sv
// Purpose: issues one ALU-class instruction (1000 r fff) to the relay ALU and writes the result to A or D.
// Latency: accept edge = cycle 0; done/dest_we in cycle SETTLE_CYCLES+2; ready again in SETTLE_CYCLES+3.
// Backpressure: instr_ready is high only in IDLE; offers made while busy wait until IDLE.
// Ports: clk, rst_n (async active-low), bus (alu_instr_sequencer_if.slave).
// SETTLE_CYCLES is legal in 1..15 (the settle counter is 4 bits).
module alu_instr_sequencer
   import relay_alu_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   alu_instr_sequencer_if.slave bus
);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   seq_state_e state_q, state_d;
   alu_fn_e    fn_q, fn_d;
   logic       r_q, r_d;
   logic [7:0] b_q, b_d;
   logic [7:0] c_q, c_d;
   logic [7:0] res_q, res_d;
   logic       cy_q, cy_d;
   flags_t     flags_q, flags_d;
   logic       illegal_q, illegal_d;
   logic       rdy_en_q, rdy_en_d;

   logic ready, accept, legal;
   logic timer_load, timer_dec, settle_tc;

   // rdy_en_q keeps instr_ready low while reset is asserted even though the
   // state register already reads IDLE.
   assign ready      = rdy_en_q && (state_q == IDLE);
   assign accept     = bus.instr_valid && ready;
   assign legal      = (bus.instr[7:4] == ALU_CLASS_OP);
   assign timer_load = (state_q == DRIVE);
   assign timer_dec  = (state_q == SETTLE);

   alu_settle_timer u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (SETTLE_LOAD),
      .dec      (timer_dec),
      .tc       (settle_tc)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a non-ALU byte is consumed without leaving IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept && legal) state_d = DRIVE;
         DRIVE:   state_d = SETTLE;
         SETTLE:  if (settle_tc) state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Snapshot, result capture and flag update
   always_comb begin
      fn_d      = fn_q;
      r_d       = r_q;
      b_d       = b_q;
      c_d       = c_q;
      res_d     = res_q;
      cy_d      = cy_q;
      flags_d   = flags_q;
      illegal_d = accept && !legal;
      rdy_en_d  = 1'b1;
      if (accept && legal) begin
         fn_d = alu_fn_e'(bus.instr[2:0]);
         r_d  = bus.instr[3];
         b_d  = bus.reg_b;
         c_d  = bus.reg_c;
      end
      // The relays have settled by the last SETTLE cycle.
      if ((state_q == SETTLE) && settle_tc) begin
         res_d = bus.alu_result;
         cy_d  = bus.alu_carry;
      end
      if (state_q == WRITE) begin
         flags_d.z = (res_q == 8'd0);
         flags_d.s = res_q[7];
         flags_d.c = fn_sets_carry(fn_q) ? cy_q : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fn_q      <= FN_ADD;
         r_q       <= 1'b0;
         b_q       <= 8'd0;
         c_q       <= 8'd0;
         res_q     <= 8'd0;
         cy_q      <= 1'b0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
         rdy_en_q  <= 1'b0;
      end else begin
         fn_q      <= fn_d;
         r_q       <= r_d;
         b_q       <= b_d;
         c_q       <= c_d;
         res_q     <= res_d;
         cy_q      <= cy_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
         rdy_en_q  <= rdy_en_d;
      end
   end

   // Outputs
   always_comb begin
      bus.instr_ready = ready;
      bus.alu_en      = 1'b0;
      bus.alu_b       = 8'd0;
      bus.alu_c       = 8'd0;
      bus.alu_fn      = 3'd0;
      bus.dest_we     = 1'b0;
      bus.dest_sel    = 1'b0;
      bus.dest_data   = 8'd0;
      bus.done        = 1'b0;
      bus.flag_z      = flags_q.z;
      bus.flag_s      = flags_q.s;
      bus.flag_c      = flags_q.c;
      bus.illegal     = illegal_q;
      if (state_q != IDLE) begin
         bus.alu_en = 1'b1;
         bus.alu_b  = b_q;
         bus.alu_c  = c_q;
         bus.alu_fn = fn_q;
      end
      if (state_q == WRITE) begin
         bus.dest_we   = 1'b1;
         bus.dest_sel  = r_q;
         bus.dest_data = res_q;
         bus.done      = 1'b1;
      end
   end
endmodule

// File: tb/tb_alu_instr_sequencer.sv
module tb_alu_instr_sequencer;
   localparam int S = 4;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [2:0] exp_flags = 3'b000;   // {z, s, c} the bench expects

   alu_instr_sequencer_if bus();

   alu_instr_sequencer #(.SETTLE_CYCLES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: returns {carry, result} from plain arithmetic on the fff code.
   function automatic logic [8:0] model_alu(logic [2:0] fn, logic [7:0] b, logic [7:0] c);
      case (fn)
         3'd0:    return {1'b0, b} + {1'b0, c};
         3'd1:    return {1'b0, b} + 9'd1;
         3'd2:    return {1'b0, b & c};
         3'd3:    return {1'b0, b | c};
         3'd4:    return {1'b0, b ^ c};
         3'd5:    return {1'b0, ~b};
         3'd6:    return {b[7], b[6:0], 1'b0};
         default: return 9'd0;
      endcase
   endfunction

   assign {bus.alu_carry, bus.alu_result} = model_alu(bus.alu_fn, bus.alu_b, bus.alu_c);

   function automatic logic [2:0] flags_now();
      return {bus.flag_z, bus.flag_s, bus.flag_c};
   endfunction

   // Issue one legal instruction and follow it to completion.
   task automatic run_op(input string name, input logic [7:0] ins, input logic [7:0] b,
                         input logic [7:0] c, input bit zero_b, input bit hold_off,
                         output logic [7:0] got_data);
      logic [8:0] m;
      logic [7:0] exp_data;
      logic [2:0] exp_fl;
      int  done_cyc;
      m        = model_alu(ins[2:0], b, c);
      exp_data = m[7:0];
      exp_fl   = {exp_data == 8'd0, exp_data[7], (ins[2:0] <= 3'd1) ? m[8] : 1'b0};
      got_data = 8'hxx;
      done_cyc = 0;
      @(negedge clk);
      for (int k = 0; k < 20 && bus.instr_ready !== 1'b1; k++) @(negedge clk);
      checks++;
      if (bus.instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before_issue got %b want 1", name, bus.instr_ready);
      end
      bus.instr = ins; bus.reg_b = b; bus.reg_c = c; bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.reg_b = zero_b ? 8'h00 : 8'($urandom);
      bus.reg_c = 8'($urandom);
      if (hold_off) bus.instr = 8'h40;
      else begin bus.instr_valid = 1'b0; bus.instr = 8'($urandom); end
      for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            done_cyc = k;
            got_data = bus.dest_data;
         end else begin
            checks++;
            if (bus.alu_en !== 1'b1 || bus.alu_b !== b || bus.alu_c !== c ||
                bus.alu_fn !== ins[2:0] || bus.instr_ready !== 1'b0 ||
                bus.dest_we !== 1'b0 || bus.dest_data !== 8'd0 || bus.illegal !== 1'b0) begin
               errors++;
               $display("FAIL %s busy_cycle%0d got en=%b b=%h c=%h fn=%h rdy=%b we=%b dd=%h ill=%b want en=1 b=%h c=%h fn=%h rdy=0 we=0 dd=00 ill=0",
                        name, k, bus.alu_en, bus.alu_b, bus.alu_c, bus.alu_fn, bus.instr_ready,
                        bus.dest_we, bus.dest_data, bus.illegal, b, c, ins[2:0]);
            end
         end
      end
      checks++;
      if (done_cyc != S + 2) begin
         errors++;
         $display("FAIL %s done_latency got %0d want %0d", name, done_cyc, S + 2);
      end
      if (done_cyc != 0) begin
         checks++;
         if (bus.dest_we !== 1'b1 || bus.dest_sel !== ins[3] || bus.dest_data !== exp_data ||
             bus.alu_en !== 1'b1) begin
            errors++;
            $display("FAIL %s write got we=%b sel=%b data=%h en=%b want we=1 sel=%b data=%h en=1",
                     name, bus.dest_we, bus.dest_sel, bus.dest_data, bus.alu_en, ins[3], exp_data);
         end
      end
      @(negedge clk);
      exp_flags = exp_fl;
      checks++;
      if (flags_now() !== exp_flags || bus.instr_ready !== 1'b1 || bus.done !== 1'b0 ||
          bus.dest_we !== 1'b0 || bus.alu_en !== 1'b0 || bus.dest_data !== 8'd0) begin
         errors++;
         $display("FAIL %s after_write got zsc=%b rdy=%b done=%b we=%b en=%b dd=%h want zsc=%b rdy=1 done=0 we=0 en=0 dd=00",
                  name, flags_now(), bus.instr_ready, bus.done, bus.dest_we, bus.alu_en,
                  bus.dest_data, exp_flags);
      end
   endtask

   // Offer a non-ALU byte; it must be consumed with only an illegal pulse.
   task automatic run_illegal(input string name, input logic [7:0] ins);
      @(negedge clk);
      for (int k = 0; k < 20 && bus.instr_ready !== 1'b1; k++) @(negedge clk);
      bus.instr = ins; bus.instr_valid = 1'b1;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.illegal !== 1'b1 || bus.alu_en !== 1'b0 || bus.dest_we !== 1'b0 ||
          bus.done !== 1'b0 || bus.instr_ready !== 1'b1 || flags_now() !== exp_flags) begin
         errors++;
         $display("FAIL %s pulse got ill=%b en=%b we=%b done=%b rdy=%b zsc=%b want ill=1 en=0 we=0 done=0 rdy=1 zsc=%b",
                  name, bus.illegal, bus.alu_en, bus.dest_we, bus.done, bus.instr_ready,
                  flags_now(), exp_flags);
      end
      @(negedge clk);
      checks++;
      if (bus.illegal !== 1'b0 || bus.alu_en !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL %s after got ill=%b en=%b done=%b want 0 0 0",
                  name, bus.illegal, bus.alu_en, bus.done);
      end
   endtask

   task automatic test_reset();
      logic [46:0] outs;
      rst_n = 1'b0;
      bus.instr_valid = 1'b1; bus.instr = 8'h80; bus.reg_b = 8'h7F; bus.reg_c = 8'h01;
      repeat (3) @(negedge clk);
      outs = {bus.instr_ready, bus.alu_b, bus.alu_c, bus.alu_fn, bus.alu_en, bus.dest_we,
              bus.dest_sel, bus.dest_data, bus.flag_z, bus.flag_s, bus.flag_c, bus.done,
              bus.illegal, 8'h00};
      checks++;
      if (outs !== 47'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", outs);
      end
      bus.instr_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready_after_release got %b want 1", bus.instr_ready);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.alu_en !== 1'b0 || bus.done !== 1'b0 || bus.dest_we !== 1'b0 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got en=%b done=%b we=%b ill=%b want 0",
                     bus.alu_en, bus.done, bus.dest_we, bus.illegal);
         end
      end
      exp_flags = 3'b000;
   endtask

   task automatic test_add_a();
      logic [7:0] d;
      run_op("add_a", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, d);
      checks++;
      if (d !== 8'h80 || flags_now() !== 3'b010) begin
         errors++;
         $display("FAIL add_a_const got data=%h zsc=%b want data=80 zsc=010", d, flags_now());
      end
   endtask

   task automatic test_carry_then_xor();
      logic [7:0] d;
      run_op("add_carry", 8'h80, 8'hFF, 8'h01, 1'b0, 1'b0, d);
      checks++;
      if (d !== 8'h00 || flags_now() !== 3'b101) begin
         errors++;
         $display("FAIL add_carry_const got data=%h zsc=%b want data=00 zsc=101", d, flags_now());
      end
      run_op("xor", 8'h84, 8'h55, 8'h55, 1'b0, 1'b0, d);
      checks++;
      if (d !== 8'h00 || flags_now() !== 3'b100) begin
         errors++;
         $display("FAIL xor_const got data=%h zsc=%b want data=00 zsc=100", d, flags_now());
      end
   endtask

   task automatic test_and_snapshot();
      logic [7:0] d;
      run_op("and_d", 8'h8A, 8'hF0, 8'h3C, 1'b1, 1'b0, d);
      checks++;
      if (d !== 8'h30 || flags_now() !== 3'b000) begin
         errors++;
         $display("FAIL and_d_const got data=%h zsc=%b want data=30 zsc=000", d, flags_now());
      end
   endtask

   task automatic test_illegal();
      logic [7:0] d;
      run_op("pre_illegal", 8'h80, 8'hFF, 8'h01, 1'b0, 1'b0, d);
      run_illegal("illegal_40", 8'h40);
   endtask

   task automatic test_hold_off();
      logic [7:0] d;
      run_op("hold_off", 8'h86, 8'hC3, 8'h00, 1'b0, 1'b1, d);
      // The byte offered while busy must be taken once ready returns.
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.illegal !== 1'b1 || bus.alu_en !== 1'b0) begin
         errors++;
         $display("FAIL hold_off_pending got ill=%b en=%b want ill=1 en=0", bus.illegal, bus.alu_en);
      end
   endtask

   task automatic test_reset_midop();
      logic [7:0] d;
      int bad;
      run_op("pre_midop", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, d);
      @(negedge clk);
      bus.instr = 8'h80; bus.reg_b = 8'hFF; bus.reg_c = 8'h01; bus.instr_valid = 1'b1;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.alu_en !== 1'b1) begin
         errors++;
         $display("FAIL midop_in_settle got en=%b want 1", bus.alu_en);
      end
      rst_n = 1'b0;
      #1;
      exp_flags = 3'b000;
      checks++;
      if (flags_now() !== 3'b000 || bus.alu_en !== 1'b0 || bus.dest_we !== 1'b0 ||
          bus.done !== 1'b0 || bus.instr_ready !== 1'b0) begin
         errors++;
         $display("FAIL midop_abort got zsc=%b en=%b we=%b done=%b rdy=%b want all 0",
                  flags_now(), bus.alu_en, bus.dest_we, bus.done, bus.instr_ready);
      end
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 2) rst_n = 1'b1;
         if (bus.done !== 1'b0 || bus.dest_we !== 1'b0 || bus.alu_en !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midop_no_write got %0d active cycles want 0", bad);
      end
      run_op("post_midop", 8'h80, 8'h01, 8'h02, 1'b0, 1'b0, d);
      checks++;
      if (d !== 8'h03) begin
         errors++;
         $display("FAIL post_midop_const got %h want 03", d);
      end
   endtask

   task automatic test_random();
      logic [7:0] ins, d;
      for (int i = 0; i < 24; i++) begin
         ins = 8'($urandom);
         if ($urandom_range(0, 3) != 0) ins[7:4] = 4'h8;
         else if (ins[7:4] == 4'h8) ins[7:4] = 4'h9;
         if (ins[7:4] == 4'h8)
            run_op($sformatf("rand%0d", i), ins, 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)), 1'b0, d);
         else
            run_illegal($sformatf("rand%0d_illegal", i), ins);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      bus.instr_valid = 1'b0; bus.instr = 8'h00; bus.reg_b = 8'h00; bus.reg_c = 8'h00;
      #2;
      test_reset();
      test_add_a();
      test_carry_then_xor();
      test_and_snapshot();
      test_illegal();
      test_hold_off();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
